// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// The prefetch top and its buffer both import this package.
package ifu_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int ILEN = 32;
    localparam logic [ILEN-1:0] INSTR_NOP = 32'h0000_0013;

    typedef logic [XLEN_DEFAULT-1:0] pc_t;

    localparam pc_t DEFAULT_RESET_PC = '0;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched instruction words in arrival order.
// Flush empties it in one cycle; the storage itself is never cleared.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Data array has no reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !reset) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/ifu_prefetch.sv
// Fetch unit: credit-limited word fetches into an in-order prefetch buffer,
// with redirect that flushes the buffer and squashes in-flight responses.
module ifu_prefetch
    import ifu_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    output logic            instr_valid_o,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] pc_o,
    input  logic            instr_ready_i
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] target_pc;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   squash;
    logic [CW-1:0]   count;
    logic [CW:0]     used;
    logic [ILEN-1:0] head;
    logic            full;
    logic            empty;
    logic            issue;
    logic            drop;
    logic            push;
    logic            pop;
    logic            unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc_i[1:0];
    assign target_pc = {redirect_pc_i[XLEN-1:2], 2'b00};

    // Every outstanding fetch owns a buffer slot, so a response can always land.
    assign used = {1'b0, inflight} + {1'b0, count};
    assign imem_req_o = ~reset_i & ~redirect_i
                      & (used < (CW+1)'(DEPTH));
    assign imem_addr_o = fetch_pc;
    assign issue = imem_req_o & imem_gnt_i;

    assign drop = imem_rvalid_i & (redirect_i | (squash != '0));
    assign push = imem_rvalid_i & ~drop;
    assign pop  = ~empty & instr_ready_i & ~redirect_i;

    assign instr_valid_o = ~empty;
    assign instr_o = empty ? '0 : head;
    assign pc_o = out_pc;

    fetch_fifo #(
        .WIDTH (ILEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .reset (reset_i),
        .push  (push),
        .pop   (pop),
        .flush (redirect_i),
        .wdata (imem_rdata_i),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fetch_pc <= RESET_PC;
            out_pc   <= RESET_PC;
            inflight <= '0;
            squash   <= '0;
        end else begin
            inflight <= inflight + CW'(issue) - CW'(imem_rvalid_i);
            if (redirect_i) begin
                fetch_pc <= target_pc;
                out_pc   <= target_pc;
                // No issue happens this cycle, so whatever stays outstanding is stale.
                squash   <= inflight - CW'(imem_rvalid_i);
            end else begin
                if (issue) begin
                    fetch_pc <= fetch_pc + XLEN'(4);
                end
                if (pop) begin
                    out_pc <= out_pc + XLEN'(4);
                end
                if (imem_rvalid_i && (squash != '0)) begin
                    squash <= squash - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(push && full))
                else $error("push into full prefetch buffer");
            assert (!(imem_rvalid_i && (inflight == '0)))
                else $error("response with no fetch in flight");
            assert (used <= (CW+1)'(DEPTH))
                else $error("credit invariant broken");
        end
    end

endmodule

// File: tb/tb_ifu_prefetch.sv
// Bench for ifu_prefetch: pipelined memory model plus a pc/instr scoreboard
// fed by the stimulus thread and drained by an independent monitor.
module tb_ifu_prefetch;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        instr_ready_i;

    always #5 clk = ~clk;

    ifu_prefetch #(
        .XLEN     (32),
        .DEPTH    (DEPTH),
        .RESET_PC (RST_PC)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .instr_ready_i (instr_ready_i)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    exp_t sb[$];
    req_t pend[$];
    exp_t got;
    int   checks = 0;
    int   errors = 0;
    int   lat = 1;
    int   cyc = 0;
    int   xfers = 0;
    int   x0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic expect_seq(input logic [31:0] start, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.pc = start + 32'(4 * i);
            e.instr = memf(e.pc);
            sb.push_back(e);
        end
    endtask

    task automatic wait_sb(input int budget, input string name);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s drain: %0d left, want 0", name, sb.size());
            sb.delete();
        end
    endtask

    // Memory: in-order responses, fixed latency counted from the transfer cycle.
    initial begin
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        forever begin
            @(negedge clk);
            if (reset_i) begin
                pend.delete();
            end else if (imem_req_o && imem_gnt_i) begin
                pend.push_back('{addr: imem_addr_o, due: cyc + lat});
                xfers++;
            end
            @(posedge clk);
            cyc++;
            #1;
            if (pend.size() != 0 && pend[0].due <= cyc) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = memf(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                imem_rvalid_i = 1'b0;
                imem_rdata_i  = '0;
            end
        end
    end

    // Monitor: every accepted head is compared against the next expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_i && !redirect_i && instr_valid_o && instr_ready_i
                && sb.size() != 0) begin
                got = sb.pop_front();
                checks++;
                if (pc_o !== got.pc || instr_o !== got.instr) begin
                    errors++;
                    $display("FAIL stream got pc %h instr %h want pc %h instr %h",
                             pc_o, instr_o, got.pc, got.instr);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i       = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        imem_gnt_i    = 1'b1;
        instr_ready_i = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_req", 32'(imem_req_o), 0);
        chk("rst_valid", 32'(instr_valid_o), 0);
        chk("rst_instr", instr_o, 0);
        chk("rst_pc", pc_o, RST_PC);
        chk("rst_addr", imem_addr_o, RST_PC);

        // Streaming from reset, with the pc wrapping through zero.
        tick();
        expect_seq(RST_PC, 8);
        reset_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i < 4) begin
                chk("t1_addr", imem_addr_o, RST_PC + 32'(4 * i));
            end
            chk("t1_valid", 32'(instr_valid_o), (i >= 2) ? 1 : 0);
        end
        wait_sb(20, "t1");

        // Decode stalled: credit allows exactly DEPTH fetches.
        tick();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0040;
        instr_ready_i = 1'b0;
        sb.delete();
        expect_seq(32'h0000_0040, 4);
        @(negedge clk);
        chk("t2_req_redir", 32'(imem_req_o), 0);
        tick();
        redirect_i = 1'b0;
        x0 = xfers;
        repeat (10) tick();
        chk("t2_fetches", 32'(xfers - x0), DEPTH);
        @(negedge clk);
        chk("t2_req_held", 32'(imem_req_o), 0);
        chk("t2_valid", 32'(instr_valid_o), 1);
        chk("t2_head_pc", pc_o, 32'h0000_0040);
        tick();
        instr_ready_i = 1'b1;
        wait_sb(20, "t2");

        // Three-cycle memory, redirect with fetches outstanding.
        tick();
        lat = 3;
        repeat (6) tick();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0100;
        sb.delete();
        expect_seq(32'h0000_0100, 4);
        @(negedge clk);
        chk("t3_req_redir", 32'(imem_req_o), 0);
        tick();
        redirect_i = 1'b0;
        @(negedge clk);
        chk("t3_addr", imem_addr_o, 32'h0000_0100);
        chk("t3_flushed", 32'(instr_valid_o), 0);
        chk("t3_pc", pc_o, 32'h0000_0100);
        wait_sb(40, "t3");

        // Unaligned target is forced to a word boundary.
        tick();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0203;
        sb.delete();
        expect_seq(32'h0000_0200, 4);
        tick();
        redirect_i = 1'b0;
        @(negedge clk);
        chk("t4_addr", imem_addr_o, 32'h0000_0200);
        chk("t4_pc", pc_o, 32'h0000_0200);
        wait_sb(40, "t4");

        // Redirect to the top word: stream wraps to zero.
        tick();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        sb.delete();
        expect_seq(32'hFFFF_FFFC, 3);
        tick();
        redirect_i = 1'b0;
        @(negedge clk);
        chk("t5_addr", imem_addr_o, 32'hFFFF_FFFC);
        wait_sb(40, "t5");

        // Back-to-back redirects, then a grant stall on the new target.
        tick();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0300;
        sb.delete();
        tick();
        redirect_pc_i = 32'h0000_0400;
        expect_seq(32'h0000_0400, 4);
        tick();
        redirect_i = 1'b0;
        imem_gnt_i = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("t7_addr_hold", imem_addr_o, 32'h0000_0400);
            chk("t7_req_hold", 32'(imem_req_o), 1);
        end
        tick();
        imem_gnt_i = 1'b1;
        wait_sb(40, "t7");

        // Reset with a full buffer and nothing outstanding.
        tick();
        instr_ready_i = 1'b0;
        repeat (15) tick();
        @(negedge clk);
        chk("t6_full_valid", 32'(instr_valid_o), 1);
        chk("t6_full_req", 32'(imem_req_o), 0);
        tick();
        reset_i = 1'b1;
        lat = 1;
        @(negedge clk);
        chk("t6_rst_req", 32'(imem_req_o), 0);
        tick();
        reset_i = 1'b0;
        sb.delete();
        expect_seq(RST_PC, 4);
        instr_ready_i = 1'b1;
        @(negedge clk);
        chk("t6_valid", 32'(instr_valid_o), 0);
        chk("t6_addr", imem_addr_o, RST_PC);
        chk("t6_pc", pc_o, RST_PC);
        chk("t6_instr", instr_o, 0);
        wait_sb(20, "t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
